// File: rtl/control_modos_pkg.sv
// Shared encodings and helpers for the mode controller.
// Optional feature macro: AUTOREPEAT_EN.
package control_modos_pkg;

    typedef enum logic [1:0] {
        MODO_RUN        = 2'b00,
        MODO_SET_HORA   = 2'b01,
        MODO_SET_ALARMA = 2'b10
    } modo_t;

    typedef enum logic {
        CAMPO_MIN = 1'b0,
        CAMPO_HOR = 1'b1
    } campo_t;

    function automatic modo_t siguienteModo(modo_t m);
        case (m)
            MODO_RUN:      return MODO_SET_HORA;
            MODO_SET_HORA: return MODO_SET_ALARMA;
            default:       return MODO_RUN;
        endcase
    endfunction

    // One-hot increment select, bit order {horAl, minAl, hor, min}.
    function automatic logic [3:0] selIncremento(modo_t m, campo_t c);
        logic [3:0] sel;
        sel = 4'b0000;
        if (m == MODO_SET_HORA)   sel = (c == CAMPO_MIN) ? 4'b0001 : 4'b0010;
        if (m == MODO_SET_ALARMA) sel = (c == CAMPO_MIN) ? 4'b0100 : 4'b1000;
        return sel;
    endfunction

endpackage

// File: rtl/control_modos_if.sv
// Button/tick inputs and mode/increment outputs of the mode controller.
interface control_modos_if;
    logic       tickSeg;
    logic       tickRep;
    logic       bModo;
    logic       bCampo;
    logic       bAumentar;
    logic [1:0] modo;
    logic       displayActual;
    logic       aumentarMin;
    logic       aumentarHor;
    logic       aumentarMinAl;
    logic       aumentarHorAl;
    logic       parpadeo;

    modport master (
        output tickSeg, tickRep, bModo, bCampo, bAumentar,
        input  modo, displayActual, aumentarMin, aumentarHor,
               aumentarMinAl, aumentarHorAl, parpadeo
    );

    modport slave (
        input  tickSeg, tickRep, bModo, bCampo, bAumentar,
        output modo, displayActual, aumentarMin, aumentarHor,
               aumentarMinAl, aumentarHorAl, parpadeo
    );
endinterface

// File: rtl/control_modos_detector_flanco.sv
// Registered rising-edge detector; history starts at 1 so a button held
// through reset never produces an edge.
module detector_flanco (
    input  logic clock,
    input  logic reset,
    input  logic boton,
    output logic flanco
);
    logic historia;

    always_ff @(posedge clock) begin
        if (reset) begin
            historia <= 1'b1;
            flanco   <= 1'b0;
        end else begin
            historia <= boton;
            flanco   <= boton & ~historia;
        end
    end
endmodule

// File: rtl/control_modos.sv
// Clock/alarm setting mode controller: RUN -> SET_TIME -> SET_ALARM FSM,
// field select, increment pulses, blink and idle timeout. Macro: AUTOREPEAT_EN.
module control_modos
    import control_modos_pkg::*;
#(
    parameter int TIMEOUT_SEG = 30,
    parameter int REPEAT_HOLD = 8
) (
    input  logic             clock,
    input  logic             reset,
    control_modos_if.slave   bus
);
    localparam int CW = $clog2(TIMEOUT_SEG + 1);

    logic          flancoModo, flancoCampo, flancoAumentar;
    modo_t         estado;
    campo_t        campo;
    logic [CW-1:0] cntTimeout;
    logic [3:0]    incPulse;
    logic          parpadeo;
    logic          setState, anyEdge, repPulse, timeout;

    detector_flanco uFlancoModo     (.clock(clock), .reset(reset), .boton(bus.bModo),     .flanco(flancoModo));
    detector_flanco uFlancoCampo    (.clock(clock), .reset(reset), .boton(bus.bCampo),    .flanco(flancoCampo));
    detector_flanco uFlancoAumentar (.clock(clock), .reset(reset), .boton(bus.bAumentar), .flanco(flancoAumentar));

    assign setState = (estado != MODO_RUN);
    assign anyEdge  = flancoCampo | flancoAumentar;
    // Any button edge or generated pulse outranks the timeout tick.
    assign timeout  = setState && bus.tickSeg && !anyEdge && !repPulse &&
                      (cntTimeout >= CW'(TIMEOUT_SEG - 1));

`ifdef AUTOREPEAT_EN
    localparam int HW = $clog2(REPEAT_HOLD + 1);
    logic [HW-1:0] holdCnt;

    assign repPulse = setState && bus.tickRep && bus.bAumentar && (holdCnt == HW'(REPEAT_HOLD));

    always_ff @(posedge clock) begin
        if (reset || flancoModo || timeout || !bus.bAumentar || !setState)
            holdCnt <= '0;
        else if (bus.tickRep && holdCnt != HW'(REPEAT_HOLD))
            holdCnt <= holdCnt + 1'b1;
    end
`else
    assign repPulse = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= MODO_RUN;
            campo      <= CAMPO_MIN;
            cntTimeout <= '0;
            incPulse   <= '0;
            parpadeo   <= 1'b0;
        end else begin
            incPulse <= '0;
            if (flancoModo) begin
                // Mode change wins; simultaneous field/increment edges are dropped.
                estado     <= siguienteModo(estado);
                campo      <= CAMPO_MIN;
                cntTimeout <= '0;
                parpadeo   <= (siguienteModo(estado) != MODO_RUN);
            end else if (!setState) begin
                cntTimeout <= '0;
                parpadeo   <= 1'b0;
            end else if (timeout) begin
                // RUN never blinks, so the fallback entry leaves parpadeo low.
                estado     <= MODO_RUN;
                campo      <= CAMPO_MIN;
                cntTimeout <= '0;
                parpadeo   <= 1'b0;
            end else begin
                // Increment uses the field as it was before any same-cycle toggle.
                if (flancoAumentar || repPulse)
                    incPulse <= selIncremento(estado, campo);
                if (flancoCampo)
                    campo <= (campo == CAMPO_MIN) ? CAMPO_HOR : CAMPO_MIN;
                if (anyEdge || repPulse)
                    cntTimeout <= '0;
                else if (bus.tickSeg && cntTimeout != CW'(TIMEOUT_SEG))
                    cntTimeout <= cntTimeout + 1'b1;
                if (anyEdge)
                    parpadeo <= 1'b1;
                else if (bus.tickSeg)
                    parpadeo <= ~parpadeo;
            end
        end
    end

    assign bus.modo          = estado;
    assign bus.displayActual = campo;
    assign bus.aumentarMin   = incPulse[0];
    assign bus.aumentarHor   = incPulse[1];
    assign bus.aumentarMinAl = incPulse[2];
    assign bus.aumentarHorAl = incPulse[3];
    assign bus.parpadeo      = parpadeo;
endmodule

// File: tb/tb_control_modos.sv
// Directed bench for control_modos: mode cycling, field/increment, timeout,
// simultaneous edges, auto-repeat (AUTOREPEAT_EN aware) and reset behaviour.
module tb_control_modos;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nChecks = 0;
    int   nFails  = 0;
    int   cMin = 0, cHor = 0, cMinAl = 0, cHorAl = 0;
    int   bMin, bHor, bMinAl, bHorAl;

`ifdef AUTOREPEAT_EN
    localparam int EXP_REP = 5;
`else
    localparam int EXP_REP = 1;
`endif

    control_modos_if bus ();
    control_modos #(.TIMEOUT_SEG(30), .REPEAT_HOLD(8)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    always #5 clock = ~clock;

    // Outputs are registered, so each one-cycle pulse is seen on exactly one negedge.
    always @(negedge clock) begin
        cMin   += int'(bus.aumentarMin);
        cHor   += int'(bus.aumentarHor);
        cMinAl += int'(bus.aumentarMinAl);
        cHorAl += int'(bus.aumentarHorAl);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        bMin = cMin; bHor = cHor; bMinAl = cMinAl; bHorAl = cHorAl;
    endtask

    task automatic chkInc(input string tag, input int eMin, input int eHor, input int eMinAl, input int eHorAl);
        chk({tag, "_min"},   cMin - bMin,     eMin);
        chk({tag, "_hor"},   cHor - bHor,     eHor);
        chk({tag, "_minAl"}, cMinAl - bMinAl, eMinAl);
        chk({tag, "_horAl"}, cHorAl - bHorAl, eHorAl);
    endtask

    task automatic press(input int b);
        case (b)
            0: bus.bModo = 1'b1;
            1: bus.bCampo = 1'b1;
            default: bus.bAumentar = 1'b1;
        endcase
        repeat (3) @(negedge clock);
        bus.bModo = 1'b0; bus.bCampo = 1'b0; bus.bAumentar = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic tickS();
        bus.tickSeg = 1'b1;
        @(negedge clock);
        bus.tickSeg = 1'b0;
    endtask

    initial begin
        bus.tickSeg = 1'b0; bus.tickRep = 1'b0;
        bus.bModo = 1'b1; bus.bCampo = 1'b0; bus.bAumentar = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_modo",     int'(bus.modo), 0);
        chk("rst_disp",     int'(bus.displayActual), 0);
        chk("rst_parpadeo", int'(bus.parpadeo), 0);
        chk("rst_inc", int'({bus.aumentarMin, bus.aumentarHor, bus.aumentarMinAl, bus.aumentarHorAl}), 0);

        // bModo held through reset release must not advance the mode
        reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("held_modo", int'(bus.modo), 0);
        bus.bModo = 1'b0;
        repeat (2) @(negedge clock);
        chk("held_modo2", int'(bus.modo), 0);

        press(0);
        chk("p1_modo", int'(bus.modo), 1);
        chk("p1_disp", int'(bus.displayActual), 0);
        chk("p1_parpadeo", int'(bus.parpadeo), 1);
        press(0);
        chk("p2_modo", int'(bus.modo), 2);
        chk("p2_disp", int'(bus.displayActual), 0);
        press(0);
        chk("p3_modo", int'(bus.modo), 0);
        chk("p3_disp", int'(bus.displayActual), 0);

        // RUN ignores field and increment buttons
        snap();
        press(1);
        press(2);
        chk("run_disp", int'(bus.displayActual), 0);
        chkInc("run_inc", 0, 0, 0, 0);

        // SET_TIME: toggle to hours, then increment hours
        press(0);
        press(1);
        chk("st_disp", int'(bus.displayActual), 1);
        snap();
        press(2);
        chkInc("st_hor", 0, 1, 0, 0);

        // bCampo + bAumentar together: increment old field (hours), then toggle
        snap();
        bus.bCampo = 1'b1; bus.bAumentar = 1'b1;
        repeat (3) @(negedge clock);
        bus.bCampo = 1'b0; bus.bAumentar = 1'b0;
        repeat (2) @(negedge clock);
        chkInc("cmb", 0, 1, 0, 0);
        chk("cmb_disp", int'(bus.displayActual), 0);

        // bModo + bAumentar together: mode change wins, no pulse
        snap();
        bus.bModo = 1'b1; bus.bAumentar = 1'b1;
        repeat (3) @(negedge clock);
        bus.bModo = 1'b0; bus.bAumentar = 1'b0;
        repeat (2) @(negedge clock);
        chk("mw_modo", int'(bus.modo), 2);
        chkInc("mw", 0, 0, 0, 0);

        // SET_ALARM timeout, with a press coinciding with tick 29 restarting it
        tickS(); @(negedge clock);
        chk("blink_tog", int'(bus.parpadeo), 0);
        for (int i = 2; i <= 28; i++) begin tickS(); @(negedge clock); end
        snap();
        bus.bAumentar = 1'b1;
        @(negedge clock);
        tickS();
        chk("t29_modo", int'(bus.modo), 2);
        chk("t29_parpadeo", int'(bus.parpadeo), 1);
        bus.bAumentar = 1'b0;
        repeat (2) @(negedge clock);
        chkInc("t29_inc", 0, 0, 1, 0);
        for (int i = 1; i <= 29; i++) begin tickS(); @(negedge clock); end
        chk("t29b_modo", int'(bus.modo), 2);
        tickS();
        chk("to_modo", int'(bus.modo), 0);
        chk("to_disp", int'(bus.displayActual), 0);

        // Held bAumentar across 12 tickRep in SET_TIME, minutes field
        press(0);
        chk("ar_modo", int'(bus.modo), 1);
        snap();
        bus.bAumentar = 1'b1;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 12; i++) begin
            bus.tickRep = 1'b1; @(negedge clock);
            bus.tickRep = 1'b0; @(negedge clock);
        end
        bus.bAumentar = 1'b0;
        repeat (3) @(negedge clock);
        chkInc("ar", EXP_REP, 0, 0, 0);

        // Reset while holding: no further pulses, held button gives no edge after
        bus.bAumentar = 1'b1;
        repeat (3) @(negedge clock);
        snap();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.tickRep = 1'b1; @(negedge clock);
            bus.tickRep = 1'b0; @(negedge clock);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.tickRep = 1'b1; @(negedge clock);
            bus.tickRep = 1'b0; @(negedge clock);
        end
        bus.bAumentar = 1'b0;
        repeat (3) @(negedge clock);
        chkInc("rsthold", 0, 0, 0, 0);
        chk("rsthold_modo", int'(bus.modo), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
